arb_mux: RTL

Parametrised N-channel round-robin arbitrating multiplexer with a registered output stage and valid/ready handshakes on every port. It chooses one requesting input channel per cycle, moves that channel's beat into a single output register and drives a one-hot grant. The grant is guaranteed one-hot-or-zero by construction. It sits wherever several producers share one downstream consumer, replacing hand-built select logic plus a separate mux.

---
 rtl/arb_mux_if.sv | 27 ++
 rtl/arb_mux.sv | 133 +++++++++++++
 2 files changed

// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux: N request channels in, one beat out.
// slave = arbiter view, master = producer/consumer (testbench) view.
interface arb_mux_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N-1:0]   i_valid;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_last;
    logic [N-1:0]   o_ready;
    logic           o_valid;
    logic [W-1:0]   o_data;
    logic           o_last;
    logic [N-1:0]   o_sel;
    logic           i_ready;
    logic           o_busy;

    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_data, o_last, o_sel, o_busy
    );

    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_sel, o_busy
    );
endinterface

// File: rtl/arb_mux.sv
// arb_mux: N-way round-robin arbiter + registered output mux.
// Ports: clk, arst_n (async low), bus (arb_mux_if.slave).
// Define ARB_MUX_PKT_LOCK_EN to hold the grant until i_last.
module arb_mux #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic     clk,
    input  logic     arst_n,
    arb_mux_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    typedef logic [PW-1:0] idx_t;

    idx_t         ptr_q, ptr_d;
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         last_q, last_d;
    logic [N-1:0] sel_q, sel_d;

    logic [N-1:0] rr_gnt, gnt;
    idx_t         rr_g, g, g_nxt;
    logic [PW:0]  j;
    logic         space, accept, drain, g_last;

`ifdef ARB_MUX_PKT_LOCK_EN
    logic lock_q, lock_d;
    idx_t lock_ch_q, lock_ch_d;
`endif

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        rr_gnt = '0;
        rr_g   = '0;
        j      = '0;
        for (int i = 0; i < N; i++) begin
            j = {1'b0, ptr_q} + (PW+1)'(i);
            if (j >= (PW+1)'(N))
                j = j - (PW+1)'(N);
            if (rr_gnt == '0 && bus.i_valid[j[PW-1:0]]) begin
                rr_gnt[j[PW-1:0]] = 1'b1;
                rr_g = j[PW-1:0];
            end
        end
    end

    // A held lock overrides the scan even if its channel is idle.
    always_comb begin
        gnt = rr_gnt;
        g   = rr_g;
`ifdef ARB_MUX_PKT_LOCK_EN
        if (lock_q) begin
            gnt = '0;
            gnt[lock_ch_q] = bus.i_valid[lock_ch_q];
            g = lock_ch_q;
        end
`endif
    end

    assign space       = ~valid_q | bus.i_ready;
    assign bus.o_ready = gnt & {N{space}};
    assign accept      = (|gnt) & space;
    assign drain       = valid_q & bus.i_ready;
    assign g_last      = bus.i_last[g];
    assign g_nxt       = (g == idx_t'(N-1)) ? '0 : g + 1'b1;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = bus.i_data[int'(g)*W +: W];
            last_d  = g_last;
            sel_d   = gnt;
        end else if (drain) begin
            valid_d = 1'b0;
            sel_d   = '0;
        end
`ifdef ARB_MUX_PKT_LOCK_EN
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (accept) begin
            lock_d = ~g_last;
            if (g_last)
                ptr_d = g_nxt;
            else
                lock_ch_d = g;
        end
`else
        if (accept)
            ptr_d = g_nxt;
`endif
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

`ifdef ARB_MUX_PKT_LOCK_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
    assign bus.o_busy = lock_q;
`else
    assign bus.o_busy = 1'b0;
`endif

    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_last  = last_q;
    assign bus.o_sel   = sel_q;
endmodule
